pool_sequencer: RTL
===================

Name: pool_sequencer

Overview:
- Controller that sequences the hasher pool (shapool) for one job at a time.
- Holds the pool in reset while idle and during a fixed arm window, then releases it to search.
- Latches the winning nonce on success, or flags nonce-space exhaustion; raises ready in either case.
- Sits between external_io (job load, ack, abort) and shapool. Its core_reset_n_out replaces the ad hoc `reset & ~ready` core-reset gating in top.

Parameters:
- NONCE_WIDTH, 31, width of the pool's nonce counter (32 - POOL_SIZE_LOG2).
- RESET_HOLD, 4, cycles core_reset_n_out is held low in ARM before the search starts (1..255).

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  asynchronous, active-high reset
- job_load_in  input  1  single-cycle pulse: new job config is stable in external_io
- job_abort_in  input  1  single-cycle pulse: abandon the current job
- ack_in  input  1  single-cycle pulse: host has read the result; clears ready
- core_success_in  input  1  shapool success flag
- core_nonce_in  input  NONCE_WIDTH  shapool current/winning nonce
- core_reset_n_out  output  1  active-low reset to shapool
- ready_out  output  1  result available (found or exhausted); drives the ready_n tri-state and LED
- exhausted_out  output  1  qualifies ready_out: 1 = nonce space wrapped with no success
- result_nonce_out  output  NONCE_WIDTH  latched winning nonce
- busy_out  output  1  high in ARM or RUN

Behaviour:
- Reset (async, g_reset=1): state=IDLE, core_reset_n_out=0, ready_out=0, exhausted_out=0, busy_out=0, result_nonce_out=0, hold counter=0, prev_nonce=0, wrap_armed=0.
- All outputs are registered; every transition takes effect on the next g_clk edge.
- States:
  - IDLE: core_reset_n_out=0. job_load_in -> ARM.
  - ARM: core_reset_n_out=0, busy_out=1. Counter runs 0..RESET_HOLD-1, then -> RUN. Entering ARM clears result_nonce_out, ready_out, exhausted_out, prev_nonce and wrap_armed.
  - RUN: core_reset_n_out=1, busy_out=1. Every cycle: prev_nonce <= core_nonce_in, and wrap_armed set once core_nonce_in is nonzero.
    - core_success_in=1 -> FOUND; result_nonce_out <= core_nonce_in in the same edge.
    - Otherwise, wrap_armed=1 and prev_nonce=all-ones and core_nonce_in=0 -> EXHAUSTED.
  - FOUND: ready_out=1, exhausted_out=0, core_reset_n_out=0 (pool frozen).
  - EXHAUSTED: ready_out=1, exhausted_out=1, result_nonce_out=0, core_reset_n_out=0.
- From FOUND or EXHAUSTED:
  - ack_in -> IDLE, clearing ready_out and exhausted_out; result_nonce_out is retained until the next ARM.
  - job_load_in -> ARM (new job overrides an unread result).
- Abort: job_abort_in in ARM, RUN, FOUND or EXHAUSTED -> IDLE; ready_out and exhausted_out cleared.
- Priority within one cycle: abort > job_load > success > wrap > ack. Consequences:
  - job_load_in in RUN restarts ARM, and the success flag from the old job is discarded.
  - success and wrap in the same cycle -> FOUND.
- Pulses that are not valid in the current state are ignored, e.g. ack_in in IDLE/RUN, or job_load_in during ARM (no counter restart).
- Latency:
  - job_load_in to core_reset_n_out rising = RESET_HOLD+1 cycles.
  - core_success_in to ready_out = 1 cycle.
  - ready_out to core_reset_n_out low = same edge.
- g_reset mid-RUN: immediate return to the reset values, asynchronously.

Decomposition:
- Shared package pool_ctrl_pkg:
  - State encoding localparams: IDLE=3'd0, ARM=3'd1, RUN=3'd2, FOUND=3'd3, EXHAUSTED=3'd4.
  - NONCE_WIDTH default.
  - RESET_HOLD width constant (8 bits).
- One sub-module: nonce_wrap_detect. Holds the prev_nonce register and the wrap_armed flag, clears synchronously on ARM entry, and outputs a one-cycle wrap pulse.

Test Plan:
- Reset then job_load_in pulse at cycle 10 -> core_reset_n_out stays 0 through cycle 14 and rises at cycle 15 (RESET_HOLD=4); busy_out=1 from cycle 11.
- In RUN, drive core_success_in=1 with core_nonce_in=31'h0000_1A2B -> next cycle ready_out=1, exhausted_out=0, result_nonce_out=31'h0000_1A2B, core_reset_n_out=0; ack_in -> ready_out=0, state IDLE.
- In RUN, drive core_nonce_in 31'h7FFF_FFFE, 31'h7FFF_FFFF, 31'h0 with no success -> ready_out=1, exhausted_out=1 one cycle after the 0.
- Success and wrap in the same cycle with core_nonce_in=0 -> FOUND, exhausted_out=0, result_nonce_out=0.
- job_abort_in and job_load_in in the same RUN cycle -> IDLE, core_reset_n_out=0, ready_out=0; job_load_in while FOUND -> ARM, ready_out cleared, result_nonce_out=0.
- Assert g_reset asynchronously mid-RUN (between clock edges) -> all outputs are at their reset values before the next edge; the pool stays held until a new job_load_in.

Source files
------------

// File: rtl/pool_ctrl_pkg.sv
// Shared constants and state type for the hasher-pool sequencer.
// The encodings are fixed so the state can be observed and compared numerically.
package pool_ctrl_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARM       = 3'd1;
  localparam logic [2:0] RUN       = 3'd2;
  localparam logic [2:0] FOUND     = 3'd3;
  localparam logic [2:0] EXHAUSTED = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = IDLE,
    S_ARM       = ARM,
    S_RUN       = RUN,
    S_FOUND     = FOUND,
    S_EXHAUSTED = EXHAUSTED
  } pool_state_t;

  localparam int DEFAULT_NONCE_WIDTH = 31;
  localparam int HOLD_WIDTH          = 8;

endpackage

// File: rtl/nonce_wrap_detect.sv
// Detects the pool nonce counter wrapping from all-ones back to zero.
// A wrap only counts after the counter has been seen nonzero in this job.
module nonce_wrap_detect #(
  parameter int NONCE_WIDTH = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NONCE_WIDTH-1:0] nonce,
  output logic                   wrap
);

  logic [NONCE_WIDTH-1:0] prev_nonce_reg;
  logic                   wrap_armed_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_nonce_reg <= '0;
      wrap_armed_reg <= 1'b0;
    end else if (clear) begin
      prev_nonce_reg <= '0;
      wrap_armed_reg <= 1'b0;
    end else if (enable) begin
      prev_nonce_reg <= nonce;
      if (nonce != '0) begin
        wrap_armed_reg <= 1'b1;
      end
    end
  end

  // The pool is held in reset at nonce 0, so the first zero seen is not a wrap.
  assign wrap = enable & wrap_armed_reg & (&prev_nonce_reg) & (nonce == '0);

endmodule

// File: rtl/pool_sequencer.sv
// Sequences the hasher pool through one job: hold in reset, arm, search,
// then latch the winning nonce or flag exhaustion until the host responds.
module pool_sequencer
  import pool_ctrl_pkg::*;
#(
  parameter int NONCE_WIDTH = DEFAULT_NONCE_WIDTH,
  parameter int RESET_HOLD  = 4
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  input  logic                   job_load_in,
  input  logic                   job_abort_in,
  input  logic                   ack_in,
  input  logic                   core_success_in,
  input  logic [NONCE_WIDTH-1:0] core_nonce_in,
  output logic                   core_reset_n_out,
  output logic                   ready_out,
  output logic                   exhausted_out,
  output logic [NONCE_WIDTH-1:0] result_nonce_out,
  output logic                   busy_out
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_HOLD - 1);

  pool_state_t            state_reg, state_next;
  logic [HOLD_WIDTH-1:0]  hold_cnt_reg, hold_cnt_next;
  logic                   core_reset_n_reg, core_reset_n_next;
  logic                   ready_reg, ready_next;
  logic                   exhausted_reg, exhausted_next;
  logic                   busy_reg, busy_next;
  logic [NONCE_WIDTH-1:0] result_nonce_reg, result_nonce_next;
  logic                   wrap_pulse;
  logic                   arm_clear;
  logic                   in_run;

  assign in_run    = (state_reg == S_RUN);
  assign arm_clear = (state_next == S_ARM);

  nonce_wrap_detect #(
    .NONCE_WIDTH(NONCE_WIDTH)
  ) u_wrap (
    .clk   (g_clk),
    .rst   (g_reset),
    .clear (arm_clear),
    .enable(in_run),
    .nonce (core_nonce_in),
    .wrap  (wrap_pulse)
  );

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_reg        <= S_IDLE;
      hold_cnt_reg     <= '0;
      core_reset_n_reg <= 1'b0;
      ready_reg        <= 1'b0;
      exhausted_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      result_nonce_reg <= '0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      core_reset_n_reg <= core_reset_n_next;
      ready_reg        <= ready_next;
      exhausted_reg    <= exhausted_next;
      busy_reg         <= busy_next;
      result_nonce_reg <= result_nonce_next;
    end
  end

  // Arbitration order: abort, then a new job, then success, then wrap, then ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (job_load_in) state_next = S_ARM;
      end
      S_ARM: begin
        if (job_abort_in)                state_next = S_IDLE;
        else if (hold_cnt_reg == HOLD_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (job_abort_in)         state_next = S_IDLE;
        else if (job_load_in)     state_next = S_ARM;
        else if (core_success_in) state_next = S_FOUND;
        else if (wrap_pulse)      state_next = S_EXHAUSTED;
      end
      S_FOUND, S_EXHAUSTED: begin
        if (job_abort_in)     state_next = S_IDLE;
        else if (job_load_in) state_next = S_ARM;
        else if (ack_in)      state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    hold_cnt_next     = '0;
    core_reset_n_next = (state_next == S_RUN);
    busy_next         = (state_next == S_ARM) || (state_next == S_RUN);
    ready_next        = (state_next == S_FOUND) || (state_next == S_EXHAUSTED);
    exhausted_next    = (state_next == S_EXHAUSTED);
    result_nonce_next = result_nonce_reg;

    if (state_reg == S_ARM && state_next == S_ARM) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end

    if (state_next == S_ARM || state_next == S_EXHAUSTED) begin
      result_nonce_next = '0;
    end else if (state_reg == S_RUN && state_next == S_FOUND) begin
      result_nonce_next = core_nonce_in;
    end
  end

  assign core_reset_n_out = core_reset_n_reg;
  assign ready_out        = ready_reg;
  assign exhausted_out    = exhausted_reg;
  assign busy_out         = busy_reg;
  assign result_nonce_out = result_nonce_reg;

endmodule
